pattern_matcher: RTL and testbench
==================================

# pattern_matcher

Streaming key-symbol matcher that sits directly downstream of the control register. It consumes the 12-symbol key words and the enable bit from that register, watches an 8-bit Avalon-ST packet stream, and forwards the stream through a one-stage pipeline. Each end-of-packet beat carries a flag stating whether the key occurred anywhere in that packet. It also keeps a saturating count of matched packets.

## Interface
- REG_WIDTH, 32, width of one key word.
- PAT_WIDTH, 3, number of key words.
- SYM_WIDTH, 8, symbol width.
- CNT_WIDTH, 16, width of the matched-packet counter.
- KEY_LEN (localparam) = PAT_WIDTH*REG_WIDTH/SYM_WIDTH = 12 symbols.
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, asynchronous and active-low.
- pattern_i  in  [REG_WIDTH-1:0] x PAT_WIDTH  key words. pattern_i[w] holds symbols 4w..4w+3, and symbol 4w+k sits in bits 8k+7:8k. Symbol 0 is the first in time.
- wrken_i  in  1  matcher enable.
- snk_data_i  in  SYM_WIDTH  input symbol.
- snk_valid_i  in  1  input beat valid.
- snk_sop_i  in  1  start of packet.
- snk_eop_i  in  1  end of packet.
- snk_ready_o  out  1  input beat accepted when valid && ready.
- src_data_o  out  SYM_WIDTH  forwarded symbol.
- src_valid_o  out  1  output beat valid.
- src_sop_o  out  1  forwarded start of packet.
- src_eop_o  out  1  forwarded end of packet.
- src_match_o  out  1  key found in packet; meaningful only on an eop beat, 0 on all other beats.
- src_ready_i  in  1  downstream ready.
- match_cnt_o  out  CNT_WIDTH  matched packets, saturating.

## Operation
- Accept: snk_valid_i && snk_ready_o. Output handshake: src_valid_o && src_ready_i.
- snk_ready_o = !src_valid_o || src_ready_i (combinational). This gives a one-entry pipeline register with no bubble under continuous flow.
- State machine:
  - IDLE: accepted beats without SOP are forwarded with src_match_o=0 and are not examined. An accepted SOP beat moves to IN_PKT.
  - IN_PKT: an accepted EOP beat returns to IDLE. An accepted SOP beat restarts the packet: window, fill count and hit are cleared, and the snapshot is retaken.
  - An SOP and EOP on the same beat forms a 1-symbol packet and stays in or returns to IDLE with match 0.
- Snapshot: on every accepted SOP beat, pattern_i and wrken_i are latched into key and en registers. Register writes during a packet do not affect that packet.
- Window: shift register of the last KEY_LEN-1 accepted symbols of the current packet, plus a fill counter 0..KEY_LEN-1 that saturates. Both are cleared on an accepted SOP; the SOP symbol itself is the first one entered.
- match_now = en && (fill == KEY_LEN-1) && ({window, snk_data_i} == key), with the oldest symbol compared to symbol 0.
- Hit is a sticky flag set on match_now and cleared at SOP.
- On an accepted EOP beat, the registered match bit = hit || match_now. On other beats it is 0.
- Packets shorter than KEY_LEN never match. Overlapping occurrences count once per packet.
- match_cnt_o increments when an output beat with src_eop_o && src_match_o is handshaken. It saturates at all-ones.

## Timing
- Reset (asynchronous assertion, synchronous deassertion handled upstream):
  - src_valid_o, src_data_o, src_sop_o, src_eop_o, src_match_o and match_cnt_o = 0.
  - State = IDLE; window, fill, hit, key and en = 0.
  - snk_ready_o = 1.
- Latency: an accepted beat appears on src_* on the next clock edge, one cycle later.
- While src_valid_o && !src_ready_i, all src_* outputs hold stable and snk_ready_o = 0.
- Throughput: one symbol per cycle when src_ready_i = 1.
- Reset mid-packet drops the partial packet: no eop or match is emitted for it, and the counter clears.

## Test plan
- Key "HELLO WORLD!" (pattern_i[0]=32'h4C4C4548, [1]=32'h4F57204F, [2]=32'h21444C52), wrken_i=1. Send the 20-symbol packet "xxHELLO WORLD!xxxxxx" -> the eop beat has src_match_o=1 and match_cnt_o becomes 1.
- Same key, packet "HELLO WORLD" (11 symbols) and packet "HELLO_WORLD!" -> src_match_o=0 on both eops and the count is unchanged.
- The key is the last 12 symbols, ending on the eop beat -> match=1, which proves the same-beat compare path.
- wrken_i=0 at SOP, then set to 1 mid-packet; the packet contains the key -> match=0. The next packet with wrken_i=1 matches.
- Toggle src_ready_i randomly at 50% over 10 packets -> the output stream is byte-identical to the input, with no drops or duplicates, and the match count equals the number of packets containing the key.
- Preload the counter to near-saturation using CNT_WIDTH=2, then send 5 matching packets -> match_cnt_o stops at 3. Assert rst_n_i mid-packet -> all outputs read 0 immediately.

Source files
------------

// File: rtl/pattern_matcher.sv
`default_nettype none
// ============================================================================
// pattern_matcher : forwards an Avalon-ST symbol stream through one register
//                   stage and flags packets that contain a 12-symbol key.
// Revision        : 1.0
// ============================================================================
module pattern_matcher #(
  parameter int REG_WIDTH = 32,
  parameter int PAT_WIDTH = 3,
  parameter int SYM_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [PAT_WIDTH-1:0][REG_WIDTH-1:0] pattern_i,
  input  logic                                wrken_i,
  input  logic [SYM_WIDTH-1:0]                snk_data_i,
  input  logic                                snk_valid_i,
  input  logic                                snk_sop_i,
  input  logic                                snk_eop_i,
  output logic                                snk_ready_o,
  output logic [SYM_WIDTH-1:0]                src_data_o,
  output logic                                src_valid_o,
  output logic                                src_sop_o,
  output logic                                src_eop_o,
  output logic                                src_match_o,
  input  logic                                src_ready_i,
  output logic [CNT_WIDTH-1:0]                match_cnt_o
);

  localparam int KEY_LEN = PAT_WIDTH * REG_WIDTH / SYM_WIDTH;
  localparam int KEY_W   = KEY_LEN * SYM_WIDTH;
  localparam int WIN_W   = (KEY_LEN - 1) * SYM_WIDTH;
  localparam int FILL_W  = $clog2(KEY_LEN);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(KEY_LEN - 1);
  localparam logic [FILL_W-1:0]    FILL_ONE = FILL_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic                   en_q, en_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   hit_q, hit_d;
  logic                   valid_q, valid_d;
  logic [SYM_WIDTH-1:0]   data_q, data_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   match_q, match_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic accept;
  logic out_hs;
  logic match_now;

  assign snk_ready_o = !valid_q || src_ready_i;
  assign accept      = snk_valid_i && snk_ready_o;
  assign out_hs      = valid_q && src_ready_i;
  // Window holds the oldest symbol in the low bits, so the live symbol lands
  // in the key position of the last (newest) symbol.
  assign match_now   = en_q && (fill_q == FILL_MAX) && ({snk_data_i, win_q} == key_q);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    en_d    = en_q;
    win_d   = win_q;
    fill_d  = fill_q;
    hit_d   = hit_q;
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    match_d = match_q;
    cnt_d   = cnt_q;

    if (out_hs) begin
      valid_d = 1'b0;
      if (eop_q && match_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (accept) begin
      valid_d = 1'b1;
      data_d  = snk_data_i;
      sop_d   = snk_sop_i;
      eop_d   = snk_eop_i;
      match_d = 1'b0;
      if (snk_sop_i) begin
        key_d   = pattern_i;
        en_d    = wrken_i;
        win_d   = {snk_data_i, {(WIN_W - SYM_WIDTH){1'b0}}};
        fill_d  = FILL_ONE;
        hit_d   = 1'b0;
        state_d = snk_eop_i ? ST_IDLE : ST_IN_PKT;
      end else if (state_q == ST_IN_PKT) begin
        win_d = {snk_data_i, win_q[WIN_W-1:SYM_WIDTH]};
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FILL_ONE;
        end
        if (match_now) begin
          hit_d = 1'b1;
        end
        if (snk_eop_i) begin
          match_d = hit_q || match_now;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      en_q    <= 1'b0;
      win_q   <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      en_q    <= en_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src_valid_o = valid_q;
  assign src_data_o  = data_q;
  assign src_sop_o   = sop_q;
  assign src_eop_o   = eop_q;
  assign src_match_o = match_q;
  assign match_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_matcher.sv
`default_nettype none
// ============================================================================
// tb_pattern_matcher : randomized, self-checking bench for pattern_matcher.
// Revision           : 1.0
// ============================================================================
module tb_pattern_matcher;

  localparam int KL = 12;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [2:0][31:0] pattern_i;
  logic             wrken_i;
  logic [7:0]       snk_data_i;
  logic             snk_valid_i, snk_sop_i, snk_eop_i;
  logic             snk_ready_o;
  logic [7:0]       src_data_o;
  logic             src_valid_o, src_sop_o, src_eop_o, src_match_o;
  logic             src_ready_i;
  logic [15:0]      match_cnt_o;

  logic             s_ready, s_valid, s_sop, s_eop, s_match;
  logic [7:0]       s_data;
  logic [1:0]       s_cnt;

  always #5 clk_i = ~clk_i;

  pattern_matcher dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pattern_i(pattern_i), .wrken_i(wrken_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_ready_o(snk_ready_o), .src_data_o(src_data_o),
    .src_valid_o(src_valid_o), .src_sop_o(src_sop_o), .src_eop_o(src_eop_o),
    .src_match_o(src_match_o), .src_ready_i(src_ready_i), .match_cnt_o(match_cnt_o)
  );

  pattern_matcher #(.CNT_WIDTH(2)) dut_s (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pattern_i(pattern_i), .wrken_i(wrken_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_ready_o(s_ready), .src_data_o(s_data),
    .src_valid_o(s_valid), .src_sop_o(s_sop), .src_eop_o(s_eop),
    .src_match_o(s_match), .src_ready_i(src_ready_i), .match_cnt_o(s_cnt)
  );

  int checks = 0;
  int passes = 0;
  int hold_err = 0;

  // Beat records are {data, sop, eop, match}
  logic [10:0] rx[$];
  logic [10:0] exp_q[$];
  logic [7:0]  m_pkt[$];
  logic [7:0]  m_key[KL];
  logic        m_in = 1'b0;
  logic        m_en = 1'b0;
  int          m_cnt = 0;

  bit          rand_rdy = 1'b0;
  logic        held_v = 1'b0;
  logic [11:0] held;

  // Downstream: random ready, output capture and hold-stability observation
  always @(negedge clk_i) begin
    src_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (rst_n_i) begin
      if (held_v && ({src_valid_o, src_data_o, src_sop_o, src_eop_o, src_match_o} !== held))
        hold_err++;
      held_v = src_valid_o && !src_ready_i;
      held   = {src_valid_o, src_data_o, src_sop_o, src_eop_o, src_match_o};
      if (held_v && (snk_ready_o !== 1'b0)) hold_err++;
      if (src_valid_o && src_ready_i)
        rx.push_back({src_data_o, src_sop_o, src_eop_o, src_match_o});
    end else begin
      held_v = 1'b0;
    end
  end

  function automatic bit pkt_has_key();
    for (int s = 0; s + KL <= m_pkt.size(); s++) begin
      bit ok = 1'b1;
      for (int j = 0; j < KL; j++) if (m_pkt[s + j] !== m_key[j]) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Packet-level reference: a packet is the symbols from its SOP to its EOP.
  task automatic model_accept(input logic [7:0] d, input logic sop, input logic eop,
                              input logic en_s, input logic [2:0][31:0] pat_s);
    logic mt = 1'b0;
    if (sop) begin
      m_pkt.delete();
      m_in = 1'b1;
      m_en = en_s;
      for (int j = 0; j < KL; j++) m_key[j] = pat_s[j / 4][8 * (j % 4) +: 8];
    end
    if (m_in) m_pkt.push_back(d);
    if (eop && m_in) begin
      mt   = m_en && pkt_has_key();
      m_in = 1'b0;
    end
    exp_q.push_back({d, sop, eop, mt});
    if (mt && m_cnt < 65535) m_cnt++;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
    bit acc = 1'b0;
    logic en_s;
    logic [2:0][31:0] pat_s;
    @(negedge clk_i);
    snk_valid_i = 1'b1; snk_data_i = d; snk_sop_i = sop; snk_eop_i = eop;
    for (int i = 0; i < 200 && !acc; i++) begin
      #1;
      acc = snk_ready_o; en_s = wrken_i; pat_s = pattern_i;
      @(posedge clk_i);
      if (!acc) @(negedge clk_i);
    end
    #1 snk_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout got=no_accept exp=accept");
    end else begin
      model_accept(d, sop, eop, en_s, pat_s);
    end
  endtask

  task automatic send_q(input logic [7:0] q[$], input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      send_beat(q[i], i == 0, i == q.size() - 1);
      if (gaps && ($urandom_range(0, 2) == 0)) @(negedge clk_i);
    end
  endtask

  task automatic send_str(input string s);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q, 1'b0);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_i); #3;
      if (rx.size() == exp_q.size()) ok = 1'b1;
    end
    @(posedge clk_i); #1;
    if (!ok) begin
      checks++;
      $display("FAIL drain_timeout got=%0d exp=%0d", rx.size(), exp_q.size());
    end
  endtask

  function automatic int stream_errs();
    int n = (rx.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) if (rx[i] !== exp_q[i]) n++;
    return n;
  endfunction

  function automatic logic last_match();
    return (rx.size() > 0) ? rx[rx.size() - 1][0] : 1'bx;
  endfunction

  function automatic int eop_matches();
    int n = 0;
    foreach (rx[i]) if (rx[i][1] && rx[i][0]) n++;
    return n;
  endfunction

  task automatic clear_queues();
    rx.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if (src_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", src_valid_o); else passes++;
    checks++; if (src_data_o !== 8'h00) $display("FAIL rst_data got=%h exp=00", src_data_o); else passes++;
    checks++; if (src_sop_o !== 1'b0) $display("FAIL rst_sop got=%b exp=0", src_sop_o); else passes++;
    checks++; if (src_eop_o !== 1'b0) $display("FAIL rst_eop got=%b exp=0", src_eop_o); else passes++;
    checks++; if (src_match_o !== 1'b0) $display("FAIL rst_match got=%b exp=0", src_match_o); else passes++;
    checks++; if (match_cnt_o !== 16'd0) $display("FAIL rst_cnt got=%0d exp=0", match_cnt_o); else passes++;
    checks++; if (snk_ready_o !== 1'b1) $display("FAIL rst_ready got=%b exp=1", snk_ready_o); else passes++;
    checks++; if (s_cnt !== 2'd0) $display("FAIL rst_cnt_small got=%0d exp=0", s_cnt); else passes++;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    m_in = 1'b0; m_cnt = 0;
    clear_queues();
  endtask

  task automatic test_basic();
    bit ok;
    clear_queues();
    send_str("xxHELLO WORLD!xxxxxx");
    wait_drain(ok);
    checks++; if (stream_errs() !== 0) $display("FAIL basic_stream got=%0d_errs exp=0", stream_errs()); else passes++;
    checks++; if (last_match() !== 1'b1) $display("FAIL basic_match got=%b exp=1", last_match()); else passes++;
    checks++; if (match_cnt_o !== 16'd1) $display("FAIL basic_cnt got=%0d exp=1", match_cnt_o); else passes++;
  endtask

  task automatic test_near_miss();
    bit ok;
    clear_queues();
    send_str("HELLO WORLD");
    send_str("HELLO_WORLD!");
    wait_drain(ok);
    checks++; if (stream_errs() !== 0) $display("FAIL near_stream got=%0d_errs exp=0", stream_errs()); else passes++;
    checks++; if (eop_matches() !== 0) $display("FAIL near_match got=%0d exp=0", eop_matches()); else passes++;
    checks++; if (match_cnt_o !== 16'd1) $display("FAIL near_cnt got=%0d exp=1", match_cnt_o); else passes++;
  endtask

  task automatic test_tail();
    bit ok;
    clear_queues();
    send_str("abHELLO WORLD!");
    wait_drain(ok);
    checks++; if (last_match() !== 1'b1) $display("FAIL tail_match got=%b exp=1", last_match()); else passes++;
    clear_queues();
    send_str("HELLO WORLD!");
    wait_drain(ok);
    checks++; if (last_match() !== 1'b1) $display("FAIL exact_match got=%b exp=1", last_match()); else passes++;
    checks++; if (match_cnt_o !== 16'd3) $display("FAIL tail_cnt got=%0d exp=3", match_cnt_o); else passes++;
  endtask

  task automatic test_enable_snapshot();
    bit ok;
    string s = "zHELLO WORLD!z";
    clear_queues();
    wrken_i = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (i == 3) wrken_i = 1'b1;
      send_beat(s[i], i == 0, i == s.len() - 1);
    end
    wait_drain(ok);
    checks++; if (last_match() !== 1'b0) $display("FAIL en_off_match got=%b exp=0", last_match()); else passes++;
    clear_queues();
    send_str(s);
    wait_drain(ok);
    checks++; if (last_match() !== 1'b1) $display("FAIL en_on_match got=%b exp=1", last_match()); else passes++;
    checks++; if (match_cnt_o !== 16'd4) $display("FAIL en_cnt got=%0d exp=4", match_cnt_o); else passes++;
  endtask

  task automatic test_restart();
    bit ok;
    string a = "HELLO WOR";
    clear_queues();
    send_beat("q", 1'b0, 1'b0);
    send_beat("r", 1'b0, 1'b1);
    for (int i = 0; i < a.len(); i++) send_beat(a[i], i == 0, 1'b0);
    send_str("LD!");
    send_beat("a", 1'b1, 1'b0);
    send_beat("b", 1'b0, 1'b0);
    send_str("HELLO WORLD!");
    send_beat("1", 1'b1, 1'b1);
    wait_drain(ok);
    checks++; if (stream_errs() !== 0) $display("FAIL restart_stream got=%0d_errs exp=0", stream_errs()); else passes++;
    checks++; if (eop_matches() !== 1) $display("FAIL restart_matches got=%0d exp=1", eop_matches()); else passes++;
    checks++; if (match_cnt_o !== 16'd5) $display("FAIL restart_cnt got=%0d exp=5", match_cnt_o); else passes++;
  endtask

  task automatic test_random_backpressure();
    bit ok;
    int n_key = 0;
    int cnt0 = int'(match_cnt_o);
    string key = "HELLO WORLD!";
    clear_queues();
    hold_err = 0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 10; p++) begin
      logic [7:0] q[$];
      bit has = ($urandom_range(0, 1) == 1);
      int pre = $urandom_range(0, 8);
      int post = $urandom_range(has ? 0 : 1, 8);
      for (int i = 0; i < pre; i++) q.push_back(8'($urandom_range(97, 122)));
      if (has) begin
        for (int i = 0; i < key.len(); i++) q.push_back(key[i]);
        n_key++;
      end
      for (int i = 0; i < post; i++) q.push_back(8'($urandom_range(97, 122)));
      send_q(q, 1'b1);
    end
    wait_drain(ok);
    rand_rdy = 1'b0;
    @(negedge clk_i);
    checks++; if (rx.size() !== exp_q.size()) $display("FAIL rnd_len got=%0d exp=%0d", rx.size(), exp_q.size()); else passes++;
    checks++; if (stream_errs() !== 0) $display("FAIL rnd_stream got=%0d_errs exp=0", stream_errs()); else passes++;
    checks++; if (int'(match_cnt_o) - cnt0 !== n_key) $display("FAIL rnd_cnt got=%0d exp=%0d", int'(match_cnt_o) - cnt0, n_key); else passes++;
    checks++; if (match_cnt_o !== 16'(m_cnt)) $display("FAIL rnd_model_cnt got=%0d exp=%0d", match_cnt_o, m_cnt); else passes++;
    checks++; if (hold_err !== 0) $display("FAIL rnd_hold got=%0d exp=0", hold_err); else passes++;
  endtask

  task automatic test_saturation();
    bit ok;
    @(negedge clk_i); rst_n_i = 1'b0;
    @(negedge clk_i); rst_n_i = 1'b1;
    m_in = 1'b0; m_cnt = 0;
    clear_queues();
    checks++; if (s_cnt !== 2'd0) $display("FAIL sat_start got=%0d exp=0", s_cnt); else passes++;
    for (int p = 0; p < 5; p++) send_str("HELLO WORLD!");
    wait_drain(ok);
    checks++; if (s_cnt !== 2'd3) $display("FAIL sat_cnt got=%0d exp=3", s_cnt); else passes++;
    checks++; if (match_cnt_o !== 16'd5) $display("FAIL sat_wide_cnt got=%0d exp=5", match_cnt_o); else passes++;
  endtask

  task automatic test_reset_mid_packet();
    string a = "HELLO WOR";
    for (int i = 0; i < a.len(); i++) send_beat(a[i], i == 0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    checks++; if (src_valid_o !== 1'b0) $display("FAIL mid_valid got=%b exp=0", src_valid_o); else passes++;
    checks++; if (src_data_o !== 8'h00) $display("FAIL mid_data got=%h exp=00", src_data_o); else passes++;
    checks++; if (match_cnt_o !== 16'd0) $display("FAIL mid_cnt got=%0d exp=0", match_cnt_o); else passes++;
    checks++; if (s_cnt !== 2'd0) $display("FAIL mid_cnt_small got=%0d exp=0", s_cnt); else passes++;
    checks++; if (snk_ready_o !== 1'b1) $display("FAIL mid_ready got=%b exp=1", snk_ready_o); else passes++;
    clear_queues();
    m_in = 1'b0; m_cnt = 0;
    @(negedge clk_i); rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    #3;
    checks++; if (rx.size() !== 0) $display("FAIL mid_no_emit got=%0d exp=0", rx.size()); else passes++;
  endtask

  initial begin
    rst_n_i = 1'b1;
    pattern_i[0] = 32'h4C4C4548;
    pattern_i[1] = 32'h4F57204F;
    pattern_i[2] = 32'h21444C52;
    wrken_i = 1'b1;
    snk_data_i = 8'h00; snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0;
    src_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_near_miss();
    test_tail();
    test_enable_snapshot();
    test_restart();
    test_random_backpressure();
    test_saturation();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
